// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared constants and types for the hex character to word loader
//   contents: ASCII code constants, FILL/HOLD state encoding, decode result type
package hex_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_USCORE = 8'h5F;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        K_HEX  = 2'd0,
        K_SKIP = 2'd1,
        K_BAD  = 2'd2
    } kind_t;

    typedef struct packed {
        logic [3:0] nibble;
        kind_t      kind;
    } dec_t;

endpackage

// File: rtl/hex_char_decode.sv
// rtl/hex_char_decode.sv - combinational character/nibble classifier
//   in_data [7:0] : ASCII hex character (ASCII_MODE=1) or raw nibble in [3:0] (ASCII_MODE=0)
//   nibble  [3:0] : decoded value, meaningful only when kind == K_HEX
//   kind          : K_HEX, K_SKIP (separator) or K_BAD (not a hex character)
module hex_char_decode
    import hex_pkg::*;
#(
    parameter int ASCII_MODE = 1
) (
    input  logic [7:0] in_data,
    output logic [3:0] nibble,
    output kind_t      kind
);

    always_comb begin
        nibble = 4'h0;
        kind   = K_BAD;
        if (ASCII_MODE == 0) begin
            nibble = in_data[3:0];
            kind   = K_HEX;
        end else if (in_data >= CH_0 && in_data <= CH_9) begin
            nibble = in_data[3:0];
            kind   = K_HEX;
        end else if ((in_data >= CH_UA && in_data <= CH_UF) ||
                     (in_data >= CH_LA && in_data <= CH_LF)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            nibble = in_data[3:0] + 4'd9;
            kind   = K_HEX;
        end else if (in_data == CH_SPACE || in_data == CH_CR ||
                     in_data == CH_NL || in_data == CH_USCORE) begin
            kind   = K_SKIP;
        end
    end

endmodule

// File: rtl/hex_to_word_loader.sv
// rtl/hex_to_word_loader.sv - packs a stream of hex characters into WORD_W-bit words
//   clk, rst              : clock, synchronous active-high reset
//   clear                 : discard the partial or held word
//   in_valid/in_ready/in_data   : character input handshake
//   out_valid/out_ready/out_word: assembled word output handshake, first nibble in MSBs
//   nib_cnt               : nibbles collected in the current word
//   err                   : one-cycle pulse after a non-hex character is accepted
module hex_to_word_loader
    import hex_pkg::*;
#(
    parameter int WORD_W     = 128,
    parameter int ASCII_MODE = 1,
    parameter int NIB        = WORD_W / 4,
    parameter int CNT_W      = $clog2(NIB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [CNT_W-1:0]  nib_cnt,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t     state;
    logic [3:0] dec_nibble;
    kind_t      dec_kind;

    hex_char_decode #(
        .ASCII_MODE (ASCII_MODE)
    ) u_decode (
        .in_data (in_data),
        .nibble  (dec_nibble),
        .kind    (dec_kind)
    );

    // Handshake flags come straight from the state flop, so both are registered.
    assign in_ready  = (state == ST_FILL);
    assign out_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= ST_FILL;
            out_word <= '0;
            nib_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        case (dec_kind)
                            K_HEX: begin
                                out_word <= {out_word[WORD_W-5:0], dec_nibble};
                                nib_cnt  <= nib_cnt + CNT_ONE;
                                if (nib_cnt == CNT_LAST) begin
                                    state <= ST_HOLD;
                                end
                            end
                            K_BAD:   err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_HOLD: begin
                    // in_ready is low here, so any in_valid is simply not taken
                    if (out_ready) begin
                        state    <= ST_FILL;
                        out_word <= '0;
                        nib_cnt  <= '0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: doc/hex_to_word_loader.md
HEX_TO_WORD_LOADER -- requirements
Module: hex_to_word_loader

Interface
REQ-001 Parameter WORD_W, default 128, output word width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter ASCII_MODE, default 1: 1 = in_data is an ASCII hex character; 0 = in_data[3:0] is a raw nibble.
REQ-003 Derived constant NIB = WORD_W/4; CNT_W = $clog2(NIB+1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 clear  input  1  synchronous abort: discard the partial word.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  8  character or nibble.
REQ-010 out_valid  output  1  out_word holds a complete word.
REQ-011 out_ready  input  1  consumer takes out_word.
REQ-012 out_word  output  WORD_W  assembled word; first accepted nibble is in the MSBs.
REQ-013 nib_cnt  output  CNT_W  nibbles collected in the current word.
REQ-014 err  output  1  one-cycle pulse when a non-hex character is accepted.

Function
REQ-015 States: FILL and HOLD; in FILL, in_ready=1 and out_valid=0; in HOLD, in_ready=0 and out_valid=1.
REQ-016 Accept occurs when in_valid && in_ready; the transfer completes in the same cycle.
REQ-017 ASCII_MODE=1 decode: '0'-'9' to 0-9, 'A'-'F' and 'a'-'f' to 10-15; space (0x20), CR (0x0D), LF (0x0A) and '_' (0x5F) are skipped silently; any other code is invalid.
REQ-018 ASCII_MODE=0 decode: in_data[3:0] is always a valid nibble; in_data[7:4] is ignored.
REQ-019 On a valid accept: out_word <= {out_word[WORD_W-5:0], nibble}; nib_cnt increments by 1.
REQ-020 A skipped or invalid accept leaves out_word and nib_cnt unchanged; an invalid accept asserts err on the next cycle for exactly one cycle.
REQ-021 A valid accept that makes nib_cnt equal NIB moves FILL to HOLD; out_valid rises in the next cycle (latency 1 from the last nibble).
REQ-022 In HOLD, out_word and nib_cnt (=NIB) are held stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready: HOLD goes to FILL next cycle; nib_cnt <= 0; out_word <= 0.
REQ-024 No bypass: in_valid during the HOLD cycle in which out_ready is high is not accepted.
REQ-025 clear in any state: next cycle FILL, nib_cnt=0, out_word=0, err=0; clear has priority over a simultaneous accept or handoff, and that character is dropped.
REQ-026 in_data is not required to be stable when in_valid=0.

Reset
REQ-027 While rst=1 at a clock edge, the following SHALL hold next cycle: state=FILL, out_word=0, nib_cnt=0, out_valid=0, err=0, in_ready=1.
REQ-028 rst has priority over clear and all handshakes, and SHALL abort a partial or held word.

Structure
REQ-029 A shared package hex_pkg SHALL hold the ASCII code constants, the FILL/HOLD state encoding, and the decode result type (nibble[3:0], kind = HEX/SKIP/BAD).
REQ-030 Decode SHALL be a combinational sub-module hex_char_decode (in_data and ASCII_MODE in; nibble and kind out), instantiated once.
REQ-031 All state SHALL be clocked by clk only, with no latches.

Verification
REQ-032 Feed "2b7e151628aed2a6abf7158809cf4f3c" with out_ready=1 -> one cycle after the 32nd char, out_valid=1 and out_word=128'h2b7e151628aed2a6abf7158809cf4f3c.
REQ-033 Feed "2B7E_1516 28AE..." (mixed case, '_' and spaces), same data -> identical out_word; err never asserted.
REQ-034 Feed 'g' (0x67) after 5 nibbles -> err high one cycle; nib_cnt stays 5; final word unaffected.
REQ-035 Hold out_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0 throughout; out_word stable; then out_ready=1 -> FILL next cycle with nib_cnt=0.
REQ-036 Assert clear and in_valid together at nib_cnt=17 -> nib_cnt=0, out_word=0, char dropped; repeat with rst mid-HOLD -> all reset values per REQ-027.
REQ-037 ASCII_MODE=0, WORD_W=32, nibbles 0xD,0xE,0xA,0xD,0xB,0xE,0xE,0xF with in_data[7:4]=0xF -> out_word=32'hDEADBEEF.
